// File: rtl/register_file.sv
// Multi-ported register file: one synchronous write port, two combinational read ports.
// Synchronous active-high reset clears every entry; reset beats a same-cycle write.
module register_file #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write_en,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Next-state: only the addressed entry changes, and only when enabled.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (reg_write_en) begin
      regs_d[write_reg] = write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reads see stored state only; a same-cycle write is visible after the edge.
  assign read_data1 = regs_q[read_reg1];
  assign read_data2 = regs_q[read_reg2];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file with hand-computed expectations.
module tb_register_file;

  logic       clk;
  logic       rst;
  logic [2:0] write_reg;
  logic [7:0] write_data;
  logic       reg_write_en;
  logic [2:0] read_reg1;
  logic [2:0] read_reg2;
  logic [7:0] read_data1;
  logic [7:0] read_data2;

  int vectors;
  int errors;

  register_file #(
    .DATA_WIDTH(8),
    .NUM_REGS  (8),
    .ADDR_WIDTH(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .reg_write_en(reg_write_en),
    .read_reg1   (read_reg1),
    .read_reg2   (read_reg2),
    .read_data1  (read_data1),
    .read_data2  (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read both ports at index i (settled) and compare against the same expected value.
  task automatic read_both(input logic [2:0] idx, input logic [7:0] exp, input string tag);
    read_reg1 = idx;
    read_reg2 = idx;
    #1;
    check($sformatf("%s_p1_r%0d", tag, idx), read_data1, exp);
    check($sformatf("%s_p2_r%0d", tag, idx), read_data2, exp);
  endtask

  initial begin
    vectors      = 0;
    errors       = 0;
    rst          = 1'b1;
    reg_write_en = 1'b0;
    write_reg    = 3'd0;
    write_data   = 8'h00;
    read_reg1    = 3'd0;
    read_reg2    = 3'd0;

    // Reset for one edge, then every entry reads zero on both ports.
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) read_both(3'(i), 8'h00, "reset");

    // Write 0xAA to register 2; all others remain zero.
    reg_write_en = 1'b1;
    write_reg    = 3'd2;
    write_data   = 8'hAA;
    tick();
    reg_write_en = 1'b0;
    for (int i = 0; i < 8; i++) read_both(3'(i), (i == 2) ? 8'hAA : 8'h00, "wr2");

    // Disabled write to register 3 over several edges has no effect.
    write_reg  = 3'd3;
    write_data = 8'h55;
    tick();
    tick();
    tick();
    read_both(3'd3, 8'h00, "no_we");

    // Write 0xFF to register 3; ports read different registers.
    reg_write_en = 1'b1;
    write_data   = 8'hFF;
    tick();
    reg_write_en = 1'b0;
    read_reg1    = 3'd2;
    read_reg2    = 3'd3;
    #1;
    check("dual_p1", read_data1, 8'hAA);
    check("dual_p2", read_data2, 8'hFF);

    // Read-during-write to register 5: old value before the edge, new after.
    read_reg1    = 3'd5;
    reg_write_en = 1'b1;
    write_reg    = 3'd5;
    write_data   = 8'h3C;
    #1;
    check("rdw_before", read_data1, 8'h00);
    tick();
    reg_write_en = 1'b0;
    check("rdw_after", read_data1, 8'h3C);
    read_reg2 = 3'd5;
    #1;
    check("rdw_p2", read_data2, 8'h3C);

    // Back-to-back writes to register 6: last write wins.
    reg_write_en = 1'b1;
    write_reg    = 3'd6;
    write_data   = 8'h11;
    tick();
    read_reg1 = 3'd6;
    #1;
    check("b2b_first", read_data1, 8'h11);
    write_data = 8'h22;
    tick();
    check("b2b_last", read_data1, 8'h22);

    // Register 0 is an ordinary writable entry.
    write_reg  = 3'd0;
    write_data = 8'h5A;
    tick();
    reg_write_en = 1'b0;
    read_both(3'd0, 8'h5A, "reg0");

    // Reset with a concurrent write: write discarded, all entries cleared.
    rst          = 1'b1;
    reg_write_en = 1'b1;
    write_reg    = 3'd4;
    write_data   = 8'h77;
    tick();
    rst          = 1'b0;
    reg_write_en = 1'b0;
    for (int i = 0; i < 8; i++) read_both(3'(i), 8'h00, "rst_wr");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the width of each register and data port.
REQ-003 Parameter NUM_REGS, default 8, SHALL set the register count.
REQ-004 Parameter ADDR_WIDTH, default 3, SHALL set the index width; NUM_REGS SHALL equal 2**ADDR_WIDTH.
REQ-005 clk  input  1  clock; all state updates occur on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 write_reg  input  ADDR_WIDTH  index of the register to write.
REQ-008 write_data  input  DATA_WIDTH  data to write.
REQ-009 reg_write_en  input  1  write enable, active high.
REQ-010 read_reg1  input  ADDR_WIDTH  index for read port 1.
REQ-011 read_reg2  input  ADDR_WIDTH  index for read port 2.
REQ-012 read_data1  output  DATA_WIDTH  contents of register read_reg1.
REQ-013 read_data2  output  DATA_WIDTH  contents of register read_reg2.
REQ-014 Port order SHALL be: clk, rst, write_reg, write_data, reg_write_en, read_reg1, read_reg2, read_data1, read_data2.

Function
REQ-015 Storage SHALL be NUM_REGS registers of DATA_WIDTH bits; all indices, including 0, SHALL be ordinary writable registers.
REQ-016 On a rising edge with rst=0 and reg_write_en=1, register[write_reg] SHALL take write_data; no other register SHALL change.
REQ-017 On a rising edge with rst=0 and reg_write_en=0, no register SHALL change, whatever write_reg and write_data hold.
REQ-018 Reads SHALL be combinational: read_data1 = register[read_reg1] and read_data2 = register[read_reg2], both valid in the same cycle the index is applied, with zero clock latency.
REQ-019 The two read ports SHALL be independent; both may address the same register and SHALL then return identical data.
REQ-020 Read during write to the same index SHALL have no bypass: the read returns the old value until the clock edge, then the new value.
REQ-021 Consecutive writes to the same index on successive edges SHALL each take effect; the last write wins.
REQ-022 Write and read paths SHALL never produce X on outputs once reset has been applied and indices are known.

Reset
REQ-023 On a rising edge with rst=1, every register SHALL be cleared to 0.
REQ-024 rst SHALL take priority over reg_write_en; a write in a reset cycle SHALL be discarded.
REQ-025 After reset, read_data1 and read_data2 SHALL be 0 for any index.
REQ-026 Reset asserted in the middle of a write sequence SHALL clear all registers, including ones written earlier, at the next edge.
REQ-027 Register contents before the first reset SHALL be undefined; verification SHALL NOT check them.

Verification
REQ-028 Apply rst=1 for one edge, then read indices 0..7 on both ports -> all return 0x00.
REQ-029 rst=0, reg_write_en=1, write_reg=2, write_data=0xAA for one edge; set read_reg1=2 -> read_data1=0xAA, and all other registers stay 0x00.
REQ-030 reg_write_en=0, write_reg=3, write_data=0x55 for several edges -> register 3 stays 0x00.
REQ-031 Write 0xFF to register 3 with reg_write_en=1; set read_reg1=2 and read_reg2=3 -> read_data1=0xAA and read_data2=0xFF.
REQ-032 Set read_reg1=5 and write 0x3C to register 5 -> read_data1 shows the old value before the edge and 0x3C immediately after it; set read_reg2=5 -> read_data2=0x3C.
REQ-033 Set rst=1 together with reg_write_en=1, write_reg=4, write_data=0x77 -> after the edge, registers 2, 3, 4 and 5 all read 0x00.
